// File: rtl/ym3438_timing_pkg.sv
// YM3438 timing generator: shared defaults and width helper.
// Imported by the prescaler, the clock-generator top and its interface.
package ym3438_timing_pkg;

  localparam int DIV_DEFAULT    = 6;
  localparam int CYCLES_DEFAULT = 24;
  localparam int CW_DEFAULT     = 5;

  // Smallest w with 2**w >= n.
  function automatic int ym_clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/ym3438_clk_gen_if.sv
// YM3438 timing bus: raw IC in, c-phases, slot counter, synced IC out.
// YM3438_SLOT_ONEHOT_EN adds the registered one-hot slot vector.
interface ym3438_clk_gen_if
  import ym3438_timing_pkg::*;
#(
  parameter int CW = CW_DEFAULT
`ifdef YM3438_SLOT_ONEHOT_EN
  , parameter int CYCLES = CYCLES_DEFAULT
`endif
);

  logic          ic;
  logic          c1;
  logic          c2;
  logic [CW-1:0] cycle;
  logic          cycle0;
  logic          ic_sync;

`ifdef YM3438_SLOT_ONEHOT_EN
  logic [CYCLES-1:0] slot_onehot;

  modport master (
    input  ic,
    output c1, c2, cycle, cycle0, ic_sync,
    output slot_onehot
  );

  modport slave (
    output ic,
    input  c1, c2, cycle, cycle0, ic_sync,
    input  slot_onehot
  );
`else
  modport master (
    input  ic,
    output c1, c2, cycle, cycle0, ic_sync
  );

  modport slave (
    output ic,
    input  c1, c2, cycle, cycle0, ic_sync
  );
`endif

endinterface

// File: rtl/ym3438_prescaler.sv
// MCLK prescaler producing the non-overlapping c1/c2 phase enables.
// c1/c2 are registered so they stay glitch-free for the whole core.
module ym3438_prescaler
  import ym3438_timing_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic MCLK,
  input  logic reset,
  output logic c1,
  output logic c2
);

  localparam int PW = ym_clog2(DIV);
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] P_HALF = PW'(DIV / 2 - 1);

  logic [PW-1:0] p;

  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      p  <= '0;
      c1 <= 1'b0;
      c2 <= 1'b0;
    end else begin
      p  <= (p == P_LAST) ? '0 : p + 1'b1;
      c1 <= (p == P_LAST);
      c2 <= (p == P_HALF);
    end
  end

endmodule

// File: rtl/ym3438_clk_gen.sv
// YM3438 timing generator: c-phases, 24-slot counter, IC synchroniser.
// Optional YM3438_SLOT_ONEHOT_EN adds a registered one-hot slot output.
module ym3438_clk_gen
  import ym3438_timing_pkg::*;
#(
  parameter int DIV    = DIV_DEFAULT,
  parameter int CYCLES = CYCLES_DEFAULT,
  parameter int CW     = CW_DEFAULT
) (
  input logic             MCLK,
  input logic             reset,
  ym3438_clk_gen_if.master bus
);

  localparam int CW_MIN = ym_clog2(CYCLES);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  if (CW < CW_MIN) begin : g_bad_cw
    $error("CW too narrow for CYCLES");
  end

  logic          c1;
  logic          c2;
  logic [CW-1:0] cyc_q;
  logic          ic_a;
  logic          ic_b;

  ym3438_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .MCLK  (MCLK),
    .reset (reset),
    .c1    (c1),
    .c2    (c2)
  );

  // IC is sampled on c1 and retimed on c2; a held ic_sync pins the slot at 0.
  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      cyc_q <= '0;
      ic_a  <= 1'b0;
      ic_b  <= 1'b0;
    end else begin
      if (c1) ic_a <= bus.ic;
      if (c2) begin
        ic_b <= ic_a;
        if (ic_b || cyc_q == LAST) cyc_q <= '0;
        else                       cyc_q <= cyc_q + 1'b1;
      end
    end
  end

`ifdef YM3438_SLOT_ONEHOT_EN
  logic [CYCLES-1:0] oh_q;

  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      oh_q <= CYCLES'(1);
    end else if (c2) begin
      if (ic_b) oh_q <= CYCLES'(1);
      else      oh_q <= {oh_q[CYCLES-2:0], oh_q[CYCLES-1]};
    end
  end

  assign bus.slot_onehot = oh_q;
`endif

  assign bus.c1      = c1;
  assign bus.c2      = c2;
  assign bus.cycle   = cyc_q;
  assign bus.cycle0  = (cyc_q == '0);
  assign bus.ic_sync = ic_b;

endmodule

// File: tb/tb_ym3438_clk_gen.sv
// Self-checking bench for ym3438_clk_gen against an edge-count model.
// Build with YM3438_SLOT_ONEHOT_EN to also check the one-hot slot output.
module tb_ym3438_clk_gen;
  import ym3438_timing_pkg::*;

  localparam int DIV    = 6;
  localparam int CYCLES = 24;
  localparam int CW     = 5;

  logic MCLK  = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

`ifdef YM3438_SLOT_ONEHOT_EN
  ym3438_clk_gen_if #(.CW(CW), .CYCLES(CYCLES)) bus ();
`else
  ym3438_clk_gen_if #(.CW(CW)) bus ();
`endif

  ym3438_clk_gen #(
    .DIV    (DIV),
    .CYCLES (CYCLES),
    .CW     (CW)
  ) dut (
    .MCLK  (MCLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 MCLK = ~MCLK;

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  // Model: n = MCLK edges since reset release; phases follow from n alone.
  int n;
  int m_cycle;
  bit m_ica;
  bit m_icsync;

  function automatic bit f_c1(int k);
    return (k >= DIV) && (k % DIV == 0);
  endfunction

  function automatic bit f_c2(int k);
    return (k >= DIV / 2) && (k % DIV == DIV / 2);
  endfunction

  task automatic model_reset();
    n = 0;
    m_cycle = 0;
    m_ica = 1'b0;
    m_icsync = 1'b0;
  endtask

  task automatic tick();
    @(posedge MCLK);
    if (reset) begin
      model_reset();
    end else begin
      if (f_c1(n)) m_ica = bus.ic;
      if (f_c2(n)) begin
        m_cycle = m_icsync ? 0 : (m_cycle + 1) % CYCLES;
        m_icsync = m_ica;
      end
      n++;
    end
    #1;
  endtask

  logic [CW+3:0] obs;
  assign obs = {bus.c1, bus.c2, bus.cycle, bus.cycle0, bus.ic_sync};

  function automatic logic [CW+3:0] exp_vec();
    return {f_c1(n), f_c2(n), CW'(m_cycle), m_cycle == 0, m_icsync};
  endfunction

  task automatic test_reset();
    logic [CW+3:0] rv;
    rv = {1'b0, 1'b0, CW'(0), 1'b1, 1'b0};
    bus.ic = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (obs !== rv) begin
        fails++;
        $display("FAIL reset obs=%b exp=%b", obs, rv);
      end
`ifdef YM3438_SLOT_ONEHOT_EN
      tests++;
      if (bus.slot_onehot !== 24'h000001) begin
        fails++;
        $display("FAIL reset_onehot obs=%h exp=000001", bus.slot_onehot);
      end
`endif
    end
    bus.ic = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_startup();
    int first_c1;
    int first_c2;
    first_c1 = -1;
    first_c2 = -1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      tests++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL startup n=%0d obs=%b exp=%b", n, obs, exp_vec());
      end
      if (bus.c1 && first_c1 < 0) first_c1 = e;
      if (bus.c2 && first_c2 < 0) first_c2 = e;
    end
    tests++;
    if (first_c2 !== 3) begin
      fails++;
      $display("FAIL first_c2 edge=%0d exp=3", first_c2);
    end
    tests++;
    if (first_c1 !== 6) begin
      fails++;
      $display("FAIL first_c1 edge=%0d exp=6", first_c1);
    end
  endtask

  task automatic test_free_run();
    int c1n;
    int c0n;
    int both;
    logic [CYCLES-1:0] eoh;
    c1n = 0;
    c0n = 0;
    both = 0;
    bus.ic = 1'b0;
    for (int e = 0; e < 10000; e++) begin
      tick();
      tests++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL free_run n=%0d obs=%b exp=%b", n, obs, exp_vec());
      end
`ifdef YM3438_SLOT_ONEHOT_EN
      eoh = CYCLES'(1) << m_cycle;
      tests++;
      if (bus.slot_onehot !== eoh) begin
        fails++;
        $display("FAIL onehot n=%0d obs=%h exp=%h", n, bus.slot_onehot, eoh);
      end
`else
      eoh = '0;
`endif
      if (bus.c1 && bus.c2) both++;
      if (bus.c1) c1n++;
      if (bus.c1 && bus.cycle0) c0n++;
    end
    tests++;
    if (both != 0) begin
      fails++;
      $display("FAIL overlap count=%0d exp=0", both);
    end
    tests++;
    if (c1n < 10000 / DIV - 1 || c1n > 10000 / DIV + 1) begin
      fails++;
      $display("FAIL c1_count got=%0d exp=%0d+-1", c1n, 10000 / DIV);
    end
    tests++;
    if (c0n < c1n / CYCLES - 1 || c0n > c1n / CYCLES + 1) begin
      fails++;
      $display("FAIL cycle0_rate got=%0d exp=%0d+-1", c0n, c1n / CYCLES);
    end
  endtask

  task automatic test_ic_pulse();
    int guard;
    int t_c1;
    int t_rise;
    bit samp;
    guard = 0;
    while (!(m_cycle == 10 && n % DIV == 1) && guard < 1000) begin
      tick();
      guard++;
    end
    tests++;
    if (guard >= 1000) begin
      fails++;
      $display("FAIL ic_wait timeout cycle=%0d exp=10", m_cycle);
    end
    t_c1 = -1;
    t_rise = -1;
    bus.ic = 1'b1;
    for (int e = 0; e < 80; e++) begin
      if (e == 12) bus.ic = 1'b0;
      samp = f_c1(n) && bus.ic;
      tick();
      if (samp && t_c1 < 0) t_c1 = e;
      if (bus.ic_sync && t_rise < 0) t_rise = e;
      tests++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL ic_pulse n=%0d obs=%b exp=%b", n, obs, exp_vec());
      end
    end
    tests++;
    if (t_c1 < 0 || t_rise - t_c1 != DIV / 2) begin
      fails++;
      $display("FAIL ic_latency got=%0d exp=%0d", t_rise - t_c1, DIV / 2);
    end
  endtask

  task automatic test_glitch();
    int guard;
    guard = 0;
    while (!(n % DIV == 1 && !m_icsync && !m_ica) && guard < 1000) begin
      tick();
      guard++;
    end
    tests++;
    if (guard >= 1000) begin
      fails++;
      $display("FAIL glitch_wait timeout n=%0d exp=idle", n);
    end
    bus.ic = 1'b1;
    for (int e = 0; e < 3 * DIV; e++) begin
      if (e == 3) bus.ic = 1'b0;
      tick();
      tests++;
      if (bus.ic_sync !== 1'b0 || obs !== exp_vec()) begin
        fails++;
        $display("FAIL glitch n=%0d obs=%b exp=%b", n, obs, exp_vec());
      end
    end
  endtask

  task automatic test_random_ic();
    int hold;
    hold = 0;
    for (int e = 0; e < 3000; e++) begin
      if (hold == 0) begin
        bus.ic = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 20);
      end
      hold--;
      tick();
      tests++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL random_ic n=%0d obs=%b exp=%b", n, obs, exp_vec());
      end
    end
    bus.ic = 1'b0;
  endtask

  task automatic test_reset_mid();
    int guard;
    logic [CW+3:0] rv;
    rv = {1'b0, 1'b0, CW'(0), 1'b1, 1'b0};
    guard = 0;
    while (!(m_cycle == 17 && n % DIV == 4) && guard < 2000) begin
      tick();
      guard++;
    end
    tests++;
    if (guard >= 2000) begin
      fails++;
      $display("FAIL rst_wait timeout cycle=%0d exp=17", m_cycle);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (obs !== rv) begin
      fails++;
      $display("FAIL async_reset obs=%b exp=%b", obs, rv);
    end
    model_reset();
    for (int e = 0; e < 2; e++) begin
      tick();
      tests++;
      if (obs !== rv) begin
        fails++;
        $display("FAIL reset_hold obs=%b exp=%b", obs, rv);
      end
    end
    reset = 1'b0;
    for (int e = 1; e <= 200; e++) begin
      tick();
      tests++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL restart n=%0d obs=%b exp=%b", n, obs, exp_vec());
      end
    end
  endtask

  initial begin
    bus.ic = 1'b0;
    model_reset();
    test_reset();
    test_startup();
    test_free_run();
    test_ic_pulse();
    test_glitch();
    test_random_ic();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
